// File: rtl/cache_read_path.sv
// Cache load-data path: way/word select on hits, refill beat assembly on misses.
// Define RETBUF_FWD_EN for critical-word forwarding out of the refill stream.
module cache_read_path #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int OFFSET_W   = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              req_valid,
  input  logic [WAYS-1:0]                   hit,
  input  logic [OFFSET_W-1:0]               offset,
  input  logic [WAYS*LINE_WORDS*DATA_W-1:0] way_data,
  input  logic                              ret_valid,
  input  logic                              ret_last,
  input  logic [DATA_W-1:0]                 ret_data,
  output logic                              busy,
  output logic                              rdata_valid,
  output logic [DATA_W-1:0]                 rdata,
  output logic [LINE_WORDS*DATA_W-1:0]      line_data,
  output logic                              line_done
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  beat;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] hit_word;
  logic              fin;

  assign widx = offset[OFFSET_W-1 -: IDX_W];
  assign fin  = ret_valid && (ret_last || beat == LAST_IDX);

  // Descending scan so the lowest-index hit way wins.
  always_comb begin
    hit_word = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit[w]) begin
        hit_word = way_data[w*LINE_W + int'(widx)*DATA_W +: DATA_W];
      end
    end
  end

`ifdef RETBUF_FWD_EN
  logic fwd;
`else
  logic [DATA_W-1:0] idx_word;
  // The final beat is not in line_data yet, so bypass it.
  assign idx_word = (beat == idx) ? ret_data
                  : line_data[int'(idx)*DATA_W +: DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      beat        <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      line_data   <= '0;
      line_done   <= 1'b0;
`ifdef RETBUF_FWD_EN
      fwd         <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      line_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (|hit) begin
              rdata       <= hit_word;
              rdata_valid <= 1'b1;
            end else begin
              idx       <= widx;
              beat      <= '0;
              line_data <= '0;
              busy      <= 1'b1;
              state     <= REFILL;
`ifdef RETBUF_FWD_EN
              fwd       <= 1'b0;
`endif
            end
          end
        end
        REFILL: begin
          if (ret_valid) begin
            line_data[int'(beat)*DATA_W +: DATA_W] <= ret_data;
            beat <= beat + IDX_W'(1);
`ifdef RETBUF_FWD_EN
            if (!fwd && beat == idx) begin
              rdata       <= ret_data;
              rdata_valid <= 1'b1;
              fwd         <= 1'b1;
            end else if (fin && !fwd) begin
              rdata       <= '0;
              rdata_valid <= 1'b1;
            end
`endif
            if (fin) begin
              state     <= IDLE;
              busy      <= 1'b0;
              beat      <= '0;
              line_done <= 1'b1;
`ifndef RETBUF_FWD_EN
              rdata       <= idx_word;
              rdata_valid <= 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
